spi_lcd_rx: RTL and testbench
=============================

Name: spi_lcd_rx

Overview:
- SPI mode-0 receiver/responder for the 4-wire display link (cs, scl, sda, dc) driven by the team's SPI display transmitter.
- Oversamples the link in the system clock domain, deserialises MSB-first bytes and tags each with the dc level.
- Queues tagged bytes in a small first-word-fall-through FIFO for a display model or loopback checker.
- Lets benches and on-chip self-test check transmitted command/data streams without a physical panel.

Parameters:
- DATA_W, 8, bits per SPI word.
- FIFO_DEPTH, 8, FIFO entries; power of two, at least 2.
- SYNC_STAGES, 2, synchroniser flops on each of cs, scl, sda and dc.

Ports:
- clk  in  1  system clock; every flop rises on clk.
- reset  in  1  asynchronous, active-high reset.
- cs  in  1  SPI chip select, active low, asynchronous to clk.
- scl  in  1  SPI clock, idle low, asynchronous to clk.
- sda  in  1  SPI serial data, MSB first.
- dc  in  1  data/command select: 0 = command, 1 = data.
- rd_en  in  1  pop the head entry; ignored while empty.
- clr_err  in  1  synchronous clear of frame_err and overflow.
- rd_data  out  DATA_W  head-entry byte; valid while !empty.
- rd_dc  out  1  head-entry dc tag.
- empty  out  1  FIFO empty.
- full  out  1  FIFO full.
- count  out  $clog2(FIFO_DEPTH)+1  occupancy.
- frame_err  out  1  sticky; cs deasserted mid-byte.
- overflow  out  1  sticky; completed byte dropped because the FIFO was full.

Behaviour:
- Reset state:
  - rd_data=0, rd_dc=0, empty=1, full=0, count=0, frame_err=0, overflow=0.
  - FSM=IDLE, bit counter=0, shift register=0, synchroniser chains cleared to the idle levels (cs=1, scl=0, sda=0, dc=0).
- Input sampling and edge detection:
  - Each input passes through SYNC_STAGES flops.
  - One more flop on synced scl gives the previous value; a scl rise is synced scl=1 while the previous value is 0.
  - scl falling edges are unused.
- Timing constraint on the link: scl high and scl low each last at least 3 clk periods; cs setup to the first scl rise is at least 3 clk periods.
- FSM:
  - IDLE: while synced cs=1; bit counter held at 0. Synced cs=0 -> SHIFT.
  - SHIFT:
    - On each scl rise: shreg <= {shreg[DATA_W-2:0], sda_s}; bit counter +1.
    - On the DATA_W-th rise, in the same cycle: push {dc_s, completed byte} to the FIFO; bit counter wraps to 0; stay in SHIFT, so back-to-back bytes are allowed within one frame.
    - Synced cs=1 with bit counter != 0: discard the partial byte, set frame_err, go to IDLE.
    - Synced cs=1 with bit counter = 0: go to IDLE with no error.
- dc is sampled only on the final bit's scl rise; it may change between bytes.
- Latency: empty falls on the (SYNC_STAGES+2)th clk rise after the raw final scl rise; 4 cycles at default.
- FIFO read (first-word fall-through): rd_data/rd_dc always show the head entry; rd_en with !empty pops, and the next entry appears on the following cycle.
- FIFO boundary conditions:
  - Push while full with no pop: byte dropped, overflow set, FIFO contents unchanged.
  - Push and pop in the same cycle while full: both happen, count stays FIFO_DEPTH, no overflow.
  - Push and pop in the same cycle while empty: only the push takes effect.
- Pointers wrap modulo FIFO_DEPTH. count is updated in the same cycle as the push or pop.
- clr_err clears both sticky flags. If a set event coincides with clr_err, the set wins.
- Reset asserted mid-byte or mid-frame: immediate return to reset state; the partial byte and all FIFO contents are lost.

Optional Feature:
- Macro SPI_RX_BYTE_CNT_EN.
- Defined:
  - Adds output byte_cnt[15:0], counting bytes accepted into the FIFO.
  - Dropped bytes are not counted.
  - Wraps from 0xFFFF to 0; reset to 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package spi_rx_pkg:
  - DATA_W default.
  - Entry typedef {dc, data[DATA_W-1:0]}.
  - FSM state enum {IDLE, SHIFT}.
  - SYNC_STAGES default.
- One sub-module, spi_rx_fifo: parameterised first-word-fall-through FIFO with push/pop, full/empty/count and overflow detect, instantiated once.

Test Plan:
- Reset behaviour: reset=1 for 10 ns, then release -> all outputs at reset values; cs held high for 5 us -> no push, frame_err=0.
- Single command: cs=0, 0xAE shifted with dc=0, cs=1 -> 4 clk after the last scl rise empty=0, rd_data=0xAE, rd_dc=0, count=1; rd_en pulse -> empty=1.
- Back-to-back data: one cs frame carrying 0xA5 then 0x3C, dc=1 -> two entries in order {1,0xA5}, {1,0x3C}; count=2; frame_err=0.
- Aborted frame: 5 bits of 0xFF, then cs=1 -> no push, frame_err=1; next frame 0x12 is received correctly; clr_err pulse -> frame_err=0.
- Overflow: 8 bytes 0x00..0x07 with no reads -> full=1; a 9th byte 0x08 -> overflow=1, count=8; the reads return 0x00..0x07 only.
- Simultaneous push/pop at full: FIFO full, rd_en asserted on the push cycle of 0x09 -> count stays 8, overflow=0, 0x09 is read last. With SPI_RX_BYTE_CNT_EN defined, byte_cnt counts only the bytes accepted into the FIFO.

Source files
------------

// File: rtl/spi_rx_pkg.sv
// Shared types and defaults for the SPI display-link receiver.
package spi_rx_pkg;

    localparam int unsigned DATA_W_DEF      = 8;
    localparam int unsigned SYNC_STAGES_DEF = 2;

    typedef struct packed {
        logic                  dc;
        logic [DATA_W_DEF-1:0] data;
    } entry_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/spi_rx_fifo.sv
// First-word-fall-through FIFO; head entry is always visible on pop_data.
module spi_rx_fifo #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       ovf_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_n;
    logic             do_push;
    logic             do_pop;

    // A pop frees a slot in the same cycle, so a push into a full FIFO still lands when popped
    always_comb begin
        do_pop  = pop & ~empty;
        do_push = push & (~full | do_pop);
        ovf_c   = push & full & ~do_pop;
        count_n = count;
        if (do_push && !do_pop) begin
            count_n = count + CW'(1);
        end else if (!do_push && do_pop) begin
            count_n = count - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_n;
            empty <= (count_n == '0);
            full  <= (count_n == CW'(DEPTH));
        end
    end

    assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/spi_lcd_rx.sv
// SPI mode-0 receiver for the display link: oversample, deserialise, tag with dc, queue.
// Optional SPI_RX_BYTE_CNT_EN adds byte_cnt, the count of bytes accepted into the FIFO.
module spi_lcd_rx
    import spi_rx_pkg::*;
#(
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cs,
    input  logic                          scl,
    input  logic                          sda,
    input  logic                          dc,
    input  logic                          rd_en,
    input  logic                          clr_err,
    output logic [DATA_W-1:0]             rd_data,
    output logic                          rd_dc,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          frame_err,
`ifdef SPI_RX_BYTE_CNT_EN
    output logic [15:0]                   byte_cnt,
`endif
    output logic                          overflow
);

    localparam int unsigned BIT_W = $clog2(DATA_W);

    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic [SYNC_STAGES-1:0] dc_sync;
    logic                   scl_prev;
    logic                   cs_s;
    logic                   scl_s;
    logic                   sda_s;
    logic                   dc_s;
    logic                   scl_rise;

    state_t                 state, state_n;
    logic [BIT_W-1:0]       bitcnt, bitcnt_n;
    logic [DATA_W-1:0]      shreg, shreg_n;
    logic                   push_n;
    logic                   err_set;
    logic                   push_q;
    logic [DATA_W:0]        push_entry;
    logic [DATA_W:0]        head;
    logic                   ovf_c;

    // Synchronisers reset to the idle link levels so no spurious edge follows reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_sync  <= '1;
            scl_sync <= '0;
            sda_sync <= '0;
            dc_sync  <= '0;
            scl_prev <= 1'b0;
        end else begin
            cs_sync  <= {cs_sync[SYNC_STAGES-2:0], cs};
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
            dc_sync  <= {dc_sync[SYNC_STAGES-2:0], dc};
            scl_prev <= scl_sync[SYNC_STAGES-1];
        end
    end

    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign scl_s    = scl_sync[SYNC_STAGES-1];
    assign sda_s    = sda_sync[SYNC_STAGES-1];
    assign dc_s     = dc_sync[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            bitcnt     <= '0;
            shreg      <= '0;
            push_q     <= 1'b0;
            push_entry <= '0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_n;
            bitcnt     <= bitcnt_n;
            shreg      <= shreg_n;
            push_q     <= push_n;
            push_entry <= {dc_s, shreg_n};
            if (err_set) begin
                frame_err <= 1'b1;
            end else if (clr_err) begin
                frame_err <= 1'b0;
            end
            if (ovf_c) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
        end
    end

    // Completed byte is registered with its dc tag and pushed on the following cycle
    always_comb begin
        state_n  = state;
        bitcnt_n = bitcnt;
        shreg_n  = shreg;
        push_n   = 1'b0;
        err_set  = 1'b0;
        case (state)
            IDLE: begin
                bitcnt_n = '0;
                if (!cs_s) begin
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_s) begin
                    state_n  = IDLE;
                    bitcnt_n = '0;
                    shreg_n  = '0;
                    err_set  = (bitcnt != '0);
                end else if (scl_rise) begin
                    shreg_n = {shreg[DATA_W-2:0], sda_s};
                    if (bitcnt == BIT_W'(DATA_W - 1)) begin
                        push_n   = 1'b1;
                        bitcnt_n = '0;
                    end else begin
                        bitcnt_n = bitcnt + BIT_W'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    spi_rx_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_q),
        .push_data (push_entry),
        .pop       (rd_en),
        .pop_data  (head),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .ovf_c     (ovf_c)
    );

    assign rd_dc   = head[DATA_W];
    assign rd_data = head[DATA_W-1:0];

`ifdef SPI_RX_BYTE_CNT_EN
    logic accept;

    assign accept = push_q & (~full | (rd_en & ~empty));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_cnt <= '0;
        end else if (accept) begin
            byte_cnt <= byte_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_spi_lcd_rx.sv
// Directed self-checking bench for spi_lcd_rx; SPI stimulus is driven on clk falling edges.
module tb_spi_lcd_rx;

    logic       clk = 1'b0;
    logic       reset;
    logic       cs;
    logic       scl;
    logic       sda;
    logic       dc;
    logic       rd_en;
    logic       clr_err;
    logic [7:0] rd_data;
    logic       rd_dc;
    logic       empty;
    logic       full;
    logic [3:0] count;
    logic       frame_err;
    logic       overflow;
`ifdef SPI_RX_BYTE_CNT_EN
    logic [15:0] byte_cnt;
`endif

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    spi_lcd_rx dut (
        .clk       (clk),
        .reset     (reset),
        .cs        (cs),
        .scl       (scl),
        .sda       (sda),
        .dc        (dc),
        .rd_en     (rd_en),
        .clr_err   (clr_err),
        .rd_data   (rd_data),
        .rd_dc     (rd_dc),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .frame_err (frame_err),
`ifdef SPI_RX_BYTE_CNT_EN
        .byte_cnt  (byte_cnt),
`endif
        .overflow  (overflow)
    );

    task automatic frame_start();
        @(negedge clk);
        cs = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic frame_end();
        repeat (3) @(negedge clk);
        cs = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    // Sends the top n bits of v; optionally pops on the push cycle of the final bit or checks latency
    task automatic send_bits(input logic [7:0] v, input logic d, input int n,
                             input bit pop_last, input bit chk_lat);
        for (int i = 7; i >= 8 - n; i--) begin
            @(negedge clk);
            sda = v[i];
            dc  = d;
            repeat (3) @(negedge clk);
            scl = 1'b1;
            repeat (3) @(negedge clk);
            if (i == 8 - n && chk_lat) begin
                total++;
                if (empty !== 1'b1) $display("FAIL latency_early: empty=%b want 1", empty);
                else passed++;
            end
            if (i == 8 - n && pop_last) rd_en = 1'b1;
            @(negedge clk);
            rd_en = 1'b0;
            if (i == 8 - n && chk_lat) begin
                total++;
                if (empty !== 1'b0) $display("FAIL latency_due: empty=%b want 0", empty);
                else passed++;
            end
            scl = 1'b0;
        end
    endtask

    task automatic pop_one();
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; cs = 1'b1; scl = 1'b0; sda = 1'b0; dc = 1'b0;
        rd_en = 1'b0; clr_err = 1'b0;
        #10 reset = 1'b0;
        #1;
        total++;
        if ({rd_data, rd_dc, empty, full, count, frame_err, overflow} !== {8'h00, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0})
            $display("FAIL reset_outputs: rd_data=%h rd_dc=%b empty=%b full=%b count=%0d ferr=%b ovf=%b",
                     rd_data, rd_dc, empty, full, count, frame_err, overflow);
        else passed++;
        repeat (500) @(negedge clk);
        total++;
        if ({empty, count, frame_err} !== {1'b1, 4'd0, 1'b0})
            $display("FAIL idle_cs_high: empty=%b count=%0d ferr=%b want 1/0/0", empty, count, frame_err);
        else passed++;
    endtask

    task automatic test_single();
        frame_start();
        send_bits(8'hAE, 1'b0, 8, 1'b0, 1'b1);
        frame_end();
        total++;
        if ({empty, rd_data, rd_dc, count} !== {1'b0, 8'hAE, 1'b0, 4'd1})
            $display("FAIL single_cmd: empty=%b data=%h dc=%b count=%0d want 0/ae/0/1", empty, rd_data, rd_dc, count);
        else passed++;
        pop_one();
        total++;
        if (empty !== 1'b1) $display("FAIL single_pop: empty=%b want 1", empty);
        else passed++;
    endtask

    task automatic test_back_to_back();
        frame_start();
        send_bits(8'hA5, 1'b1, 8, 1'b0, 1'b0);
        send_bits(8'h3C, 1'b1, 8, 1'b0, 1'b0);
        frame_end();
        total++;
        if ({count, frame_err, rd_dc, rd_data} !== {4'd2, 1'b0, 1'b1, 8'hA5})
            $display("FAIL b2b_first: count=%0d ferr=%b dc=%b data=%h want 2/0/1/a5", count, frame_err, rd_dc, rd_data);
        else passed++;
        pop_one();
        total++;
        if ({rd_dc, rd_data, count} !== {1'b1, 8'h3C, 4'd1})
            $display("FAIL b2b_second: dc=%b data=%h count=%0d want 1/3c/1", rd_dc, rd_data, count);
        else passed++;
        pop_one();
        total++;
        if (empty !== 1'b1) $display("FAIL b2b_drain: empty=%b want 1", empty);
        else passed++;
    endtask

    task automatic test_abort();
        frame_start();
        send_bits(8'hFF, 1'b0, 5, 1'b0, 1'b0);
        frame_end();
        total++;
        if ({empty, frame_err} !== {1'b1, 1'b1})
            $display("FAIL abort: empty=%b ferr=%b want 1/1", empty, frame_err);
        else passed++;
        frame_start();
        send_bits(8'h12, 1'b0, 8, 1'b0, 1'b0);
        frame_end();
        total++;
        if ({rd_data, rd_dc, count, frame_err} !== {8'h12, 1'b0, 4'd1, 1'b1})
            $display("FAIL abort_recover: data=%h dc=%b count=%0d ferr=%b want 12/0/1/1", rd_data, rd_dc, count, frame_err);
        else passed++;
        pop_one();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        total++;
        if (frame_err !== 1'b0) $display("FAIL clr_err: ferr=%b want 0", frame_err);
        else passed++;
    endtask

    task automatic test_overflow();
        frame_start();
        for (int b = 0; b < 8; b++) send_bits(8'(b), 1'b1, 8, 1'b0, 1'b0);
        frame_end();
        total++;
        if ({full, count, overflow} !== {1'b1, 4'd8, 1'b0})
            $display("FAIL fill: full=%b count=%0d ovf=%b want 1/8/0", full, count, overflow);
        else passed++;
        frame_start();
        send_bits(8'h08, 1'b1, 8, 1'b0, 1'b0);
        frame_end();
        total++;
        if ({overflow, count, full} !== {1'b1, 4'd8, 1'b1})
            $display("FAIL overflow: ovf=%b count=%0d full=%b want 1/8/1", overflow, count, full);
        else passed++;
        for (int b = 0; b < 8; b++) begin
            total++;
            if ({rd_dc, rd_data} !== {1'b1, 8'(b)})
                $display("FAIL ovf_read%0d: dc=%b data=%h want 1/%h", b, rd_dc, rd_data, 8'(b));
            else passed++;
            pop_one();
        end
        total++;
        if (empty !== 1'b1) $display("FAIL ovf_drain: empty=%b want 1", empty);
        else passed++;
    endtask

    task automatic test_push_pop_full();
        logic [7:0] exp_q [8];
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        total++;
        if (overflow !== 1'b0) $display("FAIL ovf_clear: ovf=%b want 0", overflow);
        else passed++;
        frame_start();
        for (int b = 0; b < 8; b++) send_bits(8'(b), 1'b0, 8, 1'b0, 1'b0);
        send_bits(8'h09, 1'b0, 8, 1'b1, 1'b0);
        frame_end();
        total++;
        if ({count, overflow, full} !== {4'd8, 1'b0, 1'b1})
            $display("FAIL push_pop_full: count=%0d ovf=%b full=%b want 8/0/1", count, overflow, full);
        else passed++;
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h09};
        for (int b = 0; b < 8; b++) begin
            total++;
            if ({rd_dc, rd_data} !== {1'b0, exp_q[b]})
                $display("FAIL ppf_read%0d: dc=%b data=%h want 0/%h", b, rd_dc, rd_data, exp_q[b]);
            else passed++;
            pop_one();
        end
        total++;
        if (empty !== 1'b1) $display("FAIL ppf_drain: empty=%b want 1", empty);
        else passed++;
`ifdef SPI_RX_BYTE_CNT_EN
        total++;
        if (byte_cnt !== 16'd21) $display("FAIL byte_cnt: got %0d want 21", byte_cnt);
        else passed++;
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_abort();
        test_overflow();
        test_push_pop_full();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
